// File: rtl/cpu_controller_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_pkg : shared types and encodings for the CPU control FSM           |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package cpu_pkg;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_EXEC      = 3'd5,
      S_WRITE_REG = 3'd6
   } state_t;

   localparam logic [1:0] NSEL_RN    = 2'b00;
   localparam logic [1:0] NSEL_RD    = 2'b01;
   localparam logic [1:0] NSEL_RM    = 2'b10;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM8  = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_ALU    = 3'b101;

   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MOVIMM  = 2'b10;
   localparam logic [1:0] OP_MOVREG  = 2'b00;

endpackage
`default_nettype wire

// File: rtl/cpu_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_controller_if : decode-stage handshake and datapath control bus    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface cpu_controller_if;

   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w;
   logic [1:0] nsel;
   logic [1:0] vsel;
   logic       loada;
   logic       loadb;
   logic       loadc;
   logic       loads;
   logic       asel;
   logic       bsel;
   logic       write;

   modport master (
      output s, opcode, op,
      input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write
   );

   modport slave (
      input  s, opcode, op,
      output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write
   );

endinterface
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_controller : Moore FSM sequencing MOV/ALU instructions on datapath |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module cpu_controller
   import cpu_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       reset_n,
   cpu_controller_if.slave bus
);

   state_t     r_state;
   state_t     w_next_state;
   logic [2:0] r_opcode;
   logic [1:0] r_op;

   // Instruction fields are captured only on the WAIT->DECODE edge so later
   // changes on the decode inputs cannot disturb a running instruction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_WAIT;
         r_opcode <= 3'b000;
         r_op     <= 2'b00;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_WAIT && bus.s) begin
            r_opcode <= bus.opcode;
            r_op     <= bus.op;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_WAIT: begin
            if (bus.s) w_next_state = S_DECODE;
         end
         S_DECODE: begin
            if (r_opcode == OPC_MOV && r_op == OP_MOVIMM)
               w_next_state = S_WRITE_IMM;
            else if (r_opcode == OPC_MOV && r_op == OP_MOVREG)
               w_next_state = S_GET_B;
            else if (r_opcode == OPC_ALU)
               w_next_state = S_GET_A;
            else
               w_next_state = S_WAIT;
         end
         S_WRITE_IMM: w_next_state = S_WAIT;
         S_GET_A:     w_next_state = S_GET_B;
         S_GET_B:     w_next_state = S_EXEC;
         S_EXEC: begin
            if (r_opcode == OPC_ALU && r_op == OP_CMP)
               w_next_state = S_WAIT;
            else
               w_next_state = S_WRITE_REG;
         end
         S_WRITE_REG: w_next_state = S_WAIT;
         default:     w_next_state = S_WAIT;
      endcase
   end

   always_comb begin
      bus.w     = 1'b0;
      bus.nsel  = NSEL_RN;
      bus.vsel  = VSEL_C;
      bus.loada = 1'b0;
      bus.loadb = 1'b0;
      bus.loadc = 1'b0;
      bus.loads = 1'b0;
      bus.asel  = 1'b0;
      bus.bsel  = 1'b0;
      bus.write = 1'b0;
      case (r_state)
         S_WAIT: bus.w = 1'b1;
         S_WRITE_IMM: begin
            bus.vsel  = VSEL_IMM8;
            bus.write = 1'b1;
         end
         S_GET_A: bus.loada = 1'b1;
         S_GET_B: begin
            bus.nsel  = NSEL_RM;
            bus.loadb = 1'b1;
         end
         S_EXEC: begin
            // A MOV of a register passes Rm through the ALU with A forced to zero.
            if (r_opcode == OPC_MOV)
               bus.asel = 1'b1;
            if (r_opcode == OPC_ALU && r_op == OP_CMP)
               bus.loads = 1'b1;
            else
               bus.loadc = 1'b1;
         end
         S_WRITE_REG: begin
            bus.nsel  = NSEL_RD;
            bus.vsel  = VSEL_C;
            bus.write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  rising-edge system clock
- reset_n  input  1  asynchronous active-low reset
REQ-002 s  input  1  start; sampled only in state WAIT.
REQ-003 opcode  input  3  instruction class from the decode stage (110 = MOV, 101 = ALU).
REQ-004 op  input  2  sub-operation from the decode stage (MOV: 10 = imm, 00 = reg; ALU: 00 ADD, 01 CMP, 10 AND, 11 MVN).
REQ-005 w  output  1  idle/waiting indicator.
REQ-006 nsel  output  2  register-field select to the decode stage: 00 Rn, 01 Rd, 10 Rm.
REQ-007 vsel  output  2  writeback mux select: 00 C, 01 PC, 10 sximm8, 11 mdata.
REQ-008 loada, loadb, loadc, loads  output  1 each  datapath register load enables.
REQ-009 asel, bsel  output  1 each  ALU operand selects; asel = 1 forces A to zero, bsel = 1 selects sximm5.
REQ-010 write  output  1  register-file write enable.

Function
REQ-011 Moore FSM; states: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG.
REQ-012 All outputs SHALL be decoded from the current state only; any output not listed for a state is 0.
REQ-013 WAIT: w = 1; nsel = 00; on s = 1, opcode and op are latched into internal registers and the next state is DECODE; otherwise the FSM stays in WAIT.
REQ-014 DECODE transitions, using the latched opcode/op:
- MOV imm -> WRITE_IMM
- MOV reg -> GET_B
- ALU (any op) -> GET_A
- any other opcode/op -> WAIT (illegal; no enables asserted)
REQ-015 WRITE_IMM: nsel = 00, vsel = 10, write = 1; next WAIT.
REQ-016 GET_A: nsel = 00, loada = 1; next GET_B.
REQ-017 GET_B: nsel = 10, loadb = 1; next EXEC.
REQ-018 EXEC, by latched operation:
- MOV reg: asel = 1, bsel = 0, loadc = 1
- CMP: asel = 0, bsel = 0, loads = 1, loadc = 0; next WAIT
- ADD/AND/MVN: asel = 0, bsel = 0, loadc = 1
- all non-CMP operations go next to WRITE_REG
REQ-019 WRITE_REG: nsel = 01, vsel = 00, write = 1; next WAIT.
REQ-020 Cycles from the s-sampling edge until w returns high: MOV imm 2; MOV reg 4; CMP 4; ADD/AND/MVN 5.
REQ-021 s SHALL be ignored in every state except WAIT.
REQ-022 If s is still high when the FSM returns to WAIT, a new instruction SHALL start on the next edge (back-to-back operation allowed).
REQ-023 Changes on opcode/op after the WAIT->DECODE edge SHALL NOT affect the running instruction.
REQ-024 write, loada, loadb, loadc and loads SHALL never be high in WAIT or DECODE.

Reset
REQ-025 reset_n low SHALL immediately force state WAIT and clear the latched opcode/op to 0, regardless of clk.
REQ-026 While in reset: w = 1, all enables 0, nsel = 00, vsel = 00, asel = 0, bsel = 0.
REQ-027 Reset asserted mid-instruction SHALL abort it with no further write or load pulses.
REQ-028 After reset_n deasserts, the first s is sampled on the next rising edge.

Structure
REQ-029 Package cpu_pkg SHALL hold:
- state enum
- nsel constants (NSEL_RN, NSEL_RD, NSEL_RM)
- vsel constants (VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA)
- opcode/op constants (OPC_MOV, OPC_ALU, OP_ADD, OP_CMP, OP_AND, OP_MVN, OP_MOVIMM, OP_MOVREG)
REQ-030 No sub-module is required: one state register, one next-state block and one output-decode block.

Verification
REQ-031 Reset: hold reset_n = 0 for 3 cycles with s = 1 -> w = 1, all enables 0; first edge after release moves to DECODE.
REQ-032 MOV imm: opcode = 110, op = 10, s pulse -> DECODE, then WRITE_IMM with write = 1, vsel = 10, nsel = 00; w high 2 cycles after the s-sampling edge.
REQ-033 ADD: opcode = 101, op = 00 -> in order:
- loada with nsel = 00
- loadb with nsel = 10
- loadc with asel = 0
- write with nsel = 01, vsel = 00
- w high after 5 cycles
REQ-034 CMP: opcode = 101, op = 01 -> loads = 1 in EXEC, loadc = 0, write never asserted, back in WAIT after 4 cycles.
REQ-035 MOV reg plus illegal opcode:
- opcode = 110, op = 00 -> GET_A skipped, EXEC asel = 1, write in WRITE_REG
- opcode = 111 -> DECODE -> WAIT with zero enables
REQ-036 Abort and opcode stability: reset_n pulsed low during EXEC of ADD -> no write pulse, w = 1 immediately; opcode toggled during GET_A -> sequence unchanged.
